// File: rtl/serial_add_sched.sv
// Bit-serial adder sequencer: round-robin arbitrates two requesters onto one shared
// single-bit fullAdder cell and returns a WIDTH-bit sum plus carry-out, LSB first.

module fullAdder (
    output logic cout,
    output logic s,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_sched #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             owner,
    output logic             done
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q, s_q, sum_q;
    logic [CntW-1:0]   cnt_q;
    logic              carry_q, cout_q, owner_q, cap_q, last_q, done_q;
    logic              fa_s, fa_cout;
    logic [WIDTH-1:0]  s_shift;
    logic              idle;

    fullAdder u_fa (
        .cout (fa_cout),
        .s    (fa_s),
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q)
    );

    // New result bit enters at the MSB so the LSB-first stream lands in place.
    generate
        if (WIDTH == 1) begin : g_w1
            assign s_shift = fa_s;
        end else begin : g_wn
            assign s_shift = {fa_s, s_q[WIDTH-1:1]};
        end
    endgenerate

    // On a tie the requester that was not served last wins.
    assign idle = (state_q == StIdle);
    assign gnt0 = idle && req0 && (!req1 || last_q);
    assign gnt1 = idle && req1 && (!req0 || !last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            owner_q <= 1'b0;
            cap_q   <= 1'b0;
            last_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (gnt0 || gnt1) begin
                        a_q     <= gnt1 ? a1 : a0;
                        b_q     <= gnt1 ? b1 : b0;
                        carry_q <= gnt1 ? cin1 : cin0;
                        cnt_q   <= '0;
                        last_q  <= gnt1;
                        cap_q   <= gnt1;
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    s_q     <= s_shift;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        sum_q   <= s_shift;
                        cout_q  <= fa_cout;
                        owner_q <= cap_q;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy  = !idle;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign owner = owner_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: directed operations on a WIDTH=8 instance plus an
// exhaustive sweep on a WIDTH=3 instance, with a grant-to-done scoreboard per instance.

module tb_serial_add_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;

    // WIDTH=8 instance
    logic       req0 = 0, req1 = 0, cin0 = 0, cin1 = 0;
    logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic       gnt0, gnt1, busy, cout, owner, done;
    logic [7:0] sum;

    // WIDTH=3 instance
    logic       r3_0 = 0, r3_1 = 0, c3_0 = 0, c3_1 = 0;
    logic [2:0] x3_0 = 0, y3_0 = 0, x3_1 = 0, y3_1 = 0;
    logic       g3_0, g3_1, busy3, cout3, owner3, done3;
    logic [2:0] sum3;

    logic [9:0] q8[$];
    int         t8[$];
    logic [4:0] q3[$];
    int         t3[$];
    logic [9:0] last8 = '0;

    serial_add_sched #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .sum(sum), .cout(cout),
        .owner(owner), .done(done)
    );

    serial_add_sched #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0(r3_0), .a0(x3_0), .b0(y3_0), .cin0(c3_0),
        .req1(r3_1), .a1(x3_1), .b1(y3_1), .cin1(c3_1),
        .gnt0(g3_0), .gnt1(g3_1), .busy(busy3), .sum(sum3), .cout(cout3),
        .owner(owner3), .done(done3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for WIDTH=8: push on grant, pop and compare on done.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt0 && gnt1) chk("w8_both_gnt", 1, 0);
            if (gnt0 || gnt1) begin
                if (gnt1) q8.push_back({1'b1, {1'b0, a1} + {1'b0, b1} + 9'(cin1)});
                else      q8.push_back({1'b0, {1'b0, a0} + {1'b0, b0} + 9'(cin0)});
                t8.push_back(cyc);
            end
            if (done) begin
                if (q8.size() == 0) chk("w8_spurious_done", 1, 0);
                else begin
                    chk("w8_result", {owner, cout, sum}, q8.pop_front());
                    chk("w8_latency", cyc - t8.pop_front(), 9);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (g3_0 && g3_1) chk("w3_both_gnt", 1, 0);
            if (g3_0 || g3_1) begin
                if (g3_1) q3.push_back({1'b1, {1'b0, x3_1} + {1'b0, y3_1} + 4'(c3_1)});
                else      q3.push_back({1'b0, {1'b0, x3_0} + {1'b0, y3_0} + 4'(c3_0)});
                t3.push_back(cyc);
            end
            if (done3) begin
                if (q3.size() == 0) chk("w3_spurious_done", 1, 0);
                else begin
                    chk("w3_result", {owner3, cout3, sum3}, q3.pop_front());
                    chk("w3_latency", cyc - t3.pop_front(), 4);
                end
            end
        end
    end

    task automatic wait_gnt(input bit sel, output int who, output int at);
        who = -1;
        at  = cyc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!sel && (gnt0 || gnt1)) begin
                who = gnt1 ? 1 : 0;
                at  = cyc;
                break;
            end
            if (sel && (g3_0 || g3_1)) begin
                who = g3_1 ? 1 : 0;
                at  = cyc;
                break;
            end
        end
        if (who < 0) chk("gnt_timeout", 0, 1);
    endtask

    // One WIDTH=8 operation with busy/done timing and result-hold checks.
    task automatic op8(input bit who, input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
        int w, t;
        @(posedge clk); #1;
        if (who) begin req1 = 1; a1 = a; b1 = b; cin1 = cin; end
        else     begin req0 = 1; a0 = a; b0 = b; cin0 = cin; end
        wait_gnt(0, w, t);
        chk("op_gnt_who", w, who);
        @(posedge clk); #1;
        req0 = 0;
        req1 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("op_busy", busy, (k <= 9));
            chk("op_done", done, (k == 9));
            if (k < 9) chk("op_hold", {owner, cout, sum}, last8);
        end
        last8 = {who, {1'b0, a} + {1'b0, b} + 9'(cin)};
    endtask

    initial begin
        int w, t, prev;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_owner", owner, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {gnt0, gnt1}, 0);

        op8(0, 8'h00, 8'h00, 1'b0);
        op8(1, 8'h12, 8'h34, 1'b0);
        op8(1, 8'hFF, 8'h01, 1'b0);
        op8(0, 8'hA5, 8'h5A, 1'b1);
        chk("a5_result", {owner, cout, sum}, {1'b0, 1'b1, 8'h00});

        // Both requesters held from reset: grants must alternate every 10 cycles.
        @(posedge clk); #1;
        rst = 1;
        req0 = 1; a0 = 8'h10; b0 = 8'h20; cin0 = 0;
        req1 = 1; a1 = 8'h33; b1 = 8'h44; cin1 = 0;
        @(posedge clk); #1;
        rst = 0;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_gnt(0, w, t);
            chk("tie_who", w, g % 2);
            if (g > 0) chk("tie_gap", t - prev, 10);
            prev = t;
        end
        @(posedge clk); #1;
        req0 = 0;
        req1 = 0;
        repeat (12) @(posedge clk);
        chk("tie_last", {owner, cout, sum}, {1'b1, 1'b0, 8'h77});

        // Reset in the middle of an operation discards it.
        #1;
        req0 = 1; a0 = 8'h7F; b0 = 8'h01; cin0 = 0;
        wait_gnt(0, w, t);
        chk("abort_gnt", w, 0);
        @(posedge clk); #1;
        req0 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        q8.delete();
        t8.delete();
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_out", {owner, cout, sum, done, busy}, 0);
        last8 = '0;
        repeat (15) @(posedge clk);
        op8(1, 8'h0F, 8'hF1, 1'b1);
        chk("after_abort", {owner, cout, sum}, {1'b1, 1'b1, 8'h01});

        // Exhaustive WIDTH=3 sweep, alternating requesters.
        for (int i = 0; i < 128; i++) begin
            @(posedge clk); #1;
            if (i % 2 == 1) begin
                r3_1 = 1; x3_1 = 3'(i); y3_1 = 3'(i >> 3); c3_1 = 1'(i >> 6);
            end else begin
                r3_0 = 1; x3_0 = 3'(i); y3_0 = 3'(i >> 3); c3_0 = 1'(i >> 6);
            end
            wait_gnt(1, w, t);
            chk("w3_gnt_who", w, i % 2);
            @(posedge clk); #1;
            r3_0 = 0;
            r3_1 = 0;
            repeat (3) @(posedge clk);
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("w8_queue_empty", q8.size(), 0);
        chk("w3_queue_empty", q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
